// File: rtl/gs_sobel3x3_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : gs_pkg
//  Purpose  : Shared types and constants for the gs_sobel3x3 edge stage:
//             the FSM state encoding, the kernel selector encoding, the
//             default pixel width and the signed kernel-sum width.
//  Revision : 1.0  initial release
// ============================================================================
package gs_pkg;

   localparam int DW_DEFAULT = 12;

   // A 3x3 Sobel sum spans +/-4*(2^DW-1), which needs DW+2 magnitude bits
   // plus a sign bit.
   function automatic int sum_w(input int dw);
      return dw + 3;
   endfunction

   localparam int SUM_W = DW_DEFAULT + 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      RUN  = 2'd2
   } state_t;

   typedef enum logic {
      KERN_GX = 1'b0,
      KERN_GY = 1'b1
   } kernel_t;

endpackage
`default_nettype wire

// File: rtl/gs_sobel3x3_if.sv
`default_nettype none
// ============================================================================
//  Module   : gs_sobel3x3_if
//  Purpose  : Pixel-stream bundle between the grayscale source, the Sobel
//             stage and the downstream formatter.
//  Ports    : sof, gs_valid, gs_data, kernel_sel  (source -> stage)
//             out_valid, out_data, out_x, out_y, frame_done (stage -> sink)
//  Modports : master = stream source / result sink, slave = Sobel stage
//  Revision : 1.0  initial release
// ============================================================================
interface gs_sobel3x3_if #(
   parameter int DW = gs_pkg::DW_DEFAULT
);
   logic          sof;
   logic          gs_valid;
   logic [DW-1:0] gs_data;
   logic          kernel_sel;
   logic          out_valid;
   logic [DW-1:0] out_data;
   logic [10:0]   out_x;
   logic [9:0]    out_y;
   logic          frame_done;

   modport master (
      output sof, gs_valid, gs_data, kernel_sel,
      input  out_valid, out_data, out_x, out_y, frame_done
   );

   modport slave (
      input  sof, gs_valid, gs_data, kernel_sel,
      output out_valid, out_data, out_x, out_y, frame_done
   );
endinterface
`default_nettype wire

// File: rtl/gs_sobel3x3_line_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : gs_line_buffer
//  Purpose  : Clock-enabled shift register, DEPTH words of DW bits, with a
//             single tap at the far end. With DEPTH equal to the row width
//             the tap returns the pixel one row above the one being pushed.
//  Ports    : clk   clock
//             en_i  shift enable (one accepted pixel)
//             din_i pixel in
//             tap_o pixel pushed DEPTH enables ago
//  Revision : 1.0  initial release
// ============================================================================
module gs_line_buffer #(
   parameter int DEPTH = 640,
   parameter int DW    = 12
) (
   input  logic          clk,
   input  logic          en_i,
   input  logic [DW-1:0] din_i,
   output logic [DW-1:0] tap_o
);

   // Storage is intentionally not reset; contents are always refilled by
   // two full rows before any window that uses them is emitted.
   logic [DEPTH-1:0][DW-1:0] mem_q;

   always_ff @(posedge clk) begin
      if (en_i) begin
         mem_q <= {mem_q[DEPTH-2:0], din_i};
      end
   end

   assign tap_o = mem_q[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/gs_sobel3x3.sv
`default_nettype none
// ============================================================================
//  Module   : gs_sobel3x3
//  Purpose  : Streaming 3x3 Sobel edge stage. Consumes a raster-order
//             grayscale stream, keeps two previous rows in cascaded line
//             buffers and emits one edge value per interior pixel, two
//             cycles after the input that completes its window.
//  Ports    : clk, rst_n (async, active-low)
//             bus (gs_sobel3x3_if.slave): sof, gs_valid, gs_data,
//             kernel_sel in; out_valid, out_data, out_x, out_y,
//             frame_done out
//  Config   : CONV_ABS_EN  defined   -> out_data = |sum| >> 2
//                          undefined -> out_data = (sum < 0) ? 0 : sum >> 2
//  Revision : 1.0  initial release
// ============================================================================
module gs_sobel3x3
   import gs_pkg::*;
#(
   parameter int IMG_W = 640,
   parameter int IMG_H = 480,
   parameter int DW    = DW_DEFAULT
) (
   input  logic         clk,
   input  logic         rst_n,
   gs_sobel3x3_if.slave bus
);

   localparam int          SW       = sum_w(DW);
   localparam logic [10:0] C_X_LAST = 11'(IMG_W - 1);
   localparam logic [9:0]  C_Y_LAST = 10'(IMG_H - 1);

   function automatic logic signed [SW-1:0] ext(input logic [DW-1:0] v);
      return $signed({{(SW-DW){1'b0}}, v});
   endfunction

   // ---------------------------------------------------------------- control
   state_t      state_q, state_d;
   logic [10:0] x_q, x_d;
   logic [9:0]  y_q, y_d;
   logic        pend_q, pend_d;   // sof seen without a pixel yet
   kernel_t     kern_q, kern_d;

   logic        w_acc;
   logic [10:0] w_px;
   logic [9:0]  w_py;
   logic        w_end_row;
   logic        w_last_px;
   logic        w_emit;

   // A pixel that arrives together with sof is (0,0) of the new frame.
   assign w_px      = bus.sof ? 11'd0 : x_q;
   assign w_py      = bus.sof ? 10'd0 : y_q;
   assign w_acc     = bus.gs_valid & (bus.sof | pend_q | (state_q != IDLE));
   assign w_end_row = (w_px == C_X_LAST);
   assign w_last_px = w_end_row & (w_py == C_Y_LAST);
   assign w_emit    = w_acc & (state_q == RUN) & (w_px >= 11'd2);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         x_q     <= '0;
         y_q     <= '0;
         pend_q  <= 1'b0;
         kern_q  <= KERN_GX;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         pend_q  <= pend_d;
         kern_q  <= kern_d;
      end
   end

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      pend_d  = pend_q;
      kern_d  = kern_q;

      if (w_acc) begin
         pend_d = 1'b0;
         if (w_end_row) begin
            x_d = '0;
            y_d = (w_py == C_Y_LAST) ? 10'd0 : w_py + 10'd1;
         end else begin
            x_d = w_px + 11'd1;
            y_d = w_py;
         end
      end

      if (bus.sof) begin
         kern_d = kernel_t'(bus.kernel_sel);
         if (!bus.gs_valid) begin
            x_d    = '0;
            y_d    = '0;
            pend_d = 1'b1;
         end
         // From IDLE a bare sof only arms the start; any other state is
         // aborted straight back into FILL.
         state_d = (state_q == IDLE && !bus.gs_valid) ? IDLE : FILL;
      end else if (w_acc) begin
         unique case (state_q)
            IDLE:    state_d = FILL;
            FILL:    if (w_end_row && w_py == 10'd1) state_d = RUN;
            RUN:     if (w_last_px) state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // ------------------------------------------------------------ line buffers
   logic [DW-1:0] w_lb1_tap;   // row y-1, same column
   logic [DW-1:0] w_lb2_tap;   // row y-2, same column

   gs_line_buffer #(.DEPTH(IMG_W), .DW(DW)) u_lb1 (
      .clk   (clk),
      .en_i  (w_acc),
      .din_i (bus.gs_data),
      .tap_o (w_lb1_tap)
   );

   gs_line_buffer #(.DEPTH(IMG_W), .DW(DW)) u_lb2 (
      .clk   (clk),
      .en_i  (w_acc),
      .din_i (w_lb1_tap),
      .tap_o (w_lb2_tap)
   );

   // ------------------------------------------------------------------ window
   // Index [0]=top (y-2), [1]=mid (y-1), [2]=bottom (y). Only the two older
   // columns are registered; the newest column is the live input/taps so
   // the complete window is available in the accepting cycle.
   logic [2:0][DW-1:0] w_live;
   logic [2:0][DW-1:0] col0_q;   // column x-2
   logic [2:0][DW-1:0] col1_q;   // column x-1

   assign w_live = {bus.gs_data, w_lb1_tap, w_lb2_tap};

   always_ff @(posedge clk) begin
      if (w_acc) begin
         col0_q <= col1_q;
         col1_q <= w_live;
      end
   end

   logic signed [SW-1:0] w_gx, w_gy, w_sum;

   always_comb begin
      w_gx  = (ext(w_live[0]) + (ext(w_live[1]) <<< 1) + ext(w_live[2]))
            - (ext(col0_q[0]) + (ext(col0_q[1]) <<< 1) + ext(col0_q[2]));
      w_gy  = (ext(col0_q[2]) + (ext(col1_q[2]) <<< 1) + ext(w_live[2]))
            - (ext(col0_q[0]) + (ext(col1_q[0]) <<< 1) + ext(w_live[0]));
      w_sum = (kern_q == KERN_GY) ? w_gy : w_gx;
   end

   // ---------------------------------------------------------------- pipeline
   logic                 s1_valid_q;
   logic signed [SW-1:0] s1_sum_q;
   logic [10:0]          s1_x_q;
   logic [9:0]           s1_y_q;
   logic                 s1_last_q;

   logic                 out_valid_q;
   logic [DW-1:0]        out_data_q;
   logic [10:0]          out_x_q;
   logic [9:0]           out_y_q;
   logic                 frame_done_q;

   logic [SW-1:0]        w_mag;
   logic [DW-1:0]        w_res;

   always_comb begin
`ifdef CONV_ABS_EN
      w_mag = s1_sum_q[SW-1] ? -s1_sum_q : s1_sum_q;
`else
      w_mag = s1_sum_q[SW-1] ? '0 : s1_sum_q;
`endif
      // |sum| <= 4*(2^DW-1), so the quarter always fits DW bits.
      w_res = DW'(w_mag >> 2);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q   <= 1'b0;
         s1_sum_q     <= '0;
         s1_x_q       <= '0;
         s1_y_q       <= '0;
         s1_last_q    <= 1'b0;
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         out_x_q      <= '0;
         out_y_q      <= '0;
         frame_done_q <= 1'b0;
      end else begin
         s1_valid_q <= w_emit;
         if (w_emit) begin
            s1_sum_q  <= w_sum;
            s1_x_q    <= w_px - 11'd1;
            s1_y_q    <= w_py - 10'd1;
            s1_last_q <= w_last_px;
         end
         out_valid_q  <= s1_valid_q;
         frame_done_q <= s1_valid_q & s1_last_q;
         if (s1_valid_q) begin
            out_data_q <= w_res;
            out_x_q    <= s1_x_q;
            out_y_q    <= s1_y_q;
         end
      end
   end

   assign bus.out_valid  = out_valid_q;
   assign bus.out_data   = out_data_q;
   assign bus.out_x      = out_x_q;
   assign bus.out_y      = out_y_q;
   assign bus.frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_gs_sobel3x3.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gs_sobel3x3
//  Purpose  : Self-checking bench for gs_sobel3x3 on an 8x6 frame: a table
//             of directed frames with hand-computed edge values, plus
//             sequences for mid-frame sof and mid-frame reset.
//  Config   : expected values for the inverted step follow CONV_ABS_EN.
//  Revision : 1.0  initial release
// ============================================================================
module tb_gs_sobel3x3;

   localparam int W  = 8;
   localparam int H  = 6;
   localparam int DW = 12;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   gs_sobel3x3_if #(.DW(DW)) bus ();

   gs_sobel3x3 #(.IMG_W(W), .IMG_H(H), .DW(DW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      int          x;
      int          y;
      logic [11:0] d;
      logic        fd;
      int          cyc;
   } obs_t;

   typedef struct {
      int                 pat;
      logic               ksel;
      int                 gap;
      bit                 sof_sep;
      bit                 use_x;
      logic [7:0][11:0]   ex;   // expected value by center column
      logic [5:0][11:0]   ey;   // expected value by center row
   } scn_t;

   obs_t q_out[$];
   int   in_cyc[$];
   int   cyc      = 0;
   int   fd_stray = 0;
   int   n_checks = 0;
   int   n_pass   = 0;
   int   ctx      = 0;
   scn_t tbl[6];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (bus.out_valid)
         q_out.push_back('{x: int'(bus.out_x), y: int'(bus.out_y),
                           d: bus.out_data, fd: bus.frame_done, cyc: cyc});
      if (bus.frame_done && !bus.out_valid) fd_stray <= fd_stray + 1;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input longint act, input longint exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s (test %0d): got %0h expected %0h", nm, ctx, act, exp);
   endtask

   function automatic logic [11:0] pix(input int pat, input int x, input int y);
      case (pat)
         0:       return 12'd100;
         1:       return (x >= 5) ? 12'd4095 : 12'd0;
         2:       return (x >= 5) ? 12'd0 : 12'd4095;
         3:       return (y >= 3) ? 12'd2000 : 12'd0;
         4:       return 12'(x * 300);
         default: return 12'd0;
      endcase
   endfunction

   task automatic drive_px(input logic [11:0] d, input logic s);
      @(posedge clk); #1;
      bus.gs_valid = 1'b1;
      bus.gs_data  = d;
      bus.sof      = s;
   endtask

   task automatic idle_cyc(input logic s);
      @(posedge clk); #1;
      bus.gs_valid = 1'b0;
      bus.gs_data  = '0;
      bus.sof      = s;
   endtask

   // Full frame; kernel_sel flips right after sof has been sampled so a
   // design that does not latch it produces wrong values.
   task automatic drive_frame(input int pat, input logic ksel, input int gap,
                              input bit sof_sep);
      bus.kernel_sel = ksel;
      if (sof_sep) idle_cyc(1'b1);
      for (int y = 0; y < H; y++) begin
         for (int x = 0; x < W; x++) begin
            drive_px(pix(pat, x, y), (x == 0 && y == 0 && !sof_sep));
            if (x == 1 && y == 0) bus.kernel_sel = ~ksel;
            if (x >= 2 && y >= 2) in_cyc.push_back(cyc);
            for (int g = 0; g < gap; g++) idle_cyc(1'b0);
         end
      end
      repeat (5) idle_cyc(1'b0);
   endtask

   task automatic check_frame(input logic [7:0][11:0] ex,
                              input logic [5:0][11:0] ey,
                              input bit use_x, input int from_cyc);
      obs_t        o[$];
      int          i;
      logic [11:0] ed;
      logic        efd;
      foreach (q_out[k]) if (q_out[k].cyc >= from_cyc) o.push_back(q_out[k]);
      chk("count", o.size(), 24);
      i = 0;
      for (int cy = 1; cy <= H - 2; cy++) begin
         for (int cx = 1; cx <= W - 2; cx++) begin
            ed  = use_x ? ex[cx] : ey[cy];
            efd = (cx == W - 2 && cy == H - 2);
            if (i < o.size()) begin
               chk("out{fd,x,y,d}",
                   {o[i].fd, 11'(o[i].x), 10'(o[i].y), o[i].d},
                   {efd, 11'(cx), 10'(cy), ed});
               if (i < in_cyc.size())
                  chk("latency", o[i].cyc, in_cyc[i] + 2);
            end
            i++;
         end
      end
   endtask

   int sof_cyc;
   int n_old;

   initial begin
      bus.sof        = 1'b0;
      bus.gs_valid   = 1'b0;
      bus.gs_data    = '0;
      bus.kernel_sel = 1'b0;

      for (int i = 0; i < 6; i++) begin
         tbl[i].ex = '0;
         tbl[i].ey = '0;
         tbl[i].gap = 0;
         tbl[i].sof_sep = 1'b0;
         tbl[i].use_x = 1'b1;
         tbl[i].ksel = 1'b0;
      end
      tbl[0].pat = 0;                                   // flat
      tbl[1].pat = 1; tbl[1].ex[4] = 12'd4095; tbl[1].ex[5] = 12'd4095;
      tbl[2].pat = 2;                                   // inverted step
`ifdef CONV_ABS_EN
      tbl[2].ex[4] = 12'd4095; tbl[2].ex[5] = 12'd4095;
`endif
      tbl[3].pat = 3; tbl[3].ksel = 1'b1; tbl[3].use_x = 1'b0;
      tbl[3].ey[2] = 12'd2000; tbl[3].ey[3] = 12'd2000;
      tbl[4].pat = 0; tbl[4].gap = 1;                   // every other cycle
      tbl[5].pat = 1; tbl[5].ksel = 1'b1; tbl[5].sof_sep = 1'b1;

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_out", {bus.out_valid, bus.frame_done, bus.out_x, bus.out_y, bus.out_data}, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (2) idle_cyc(1'b0);

      for (int t = 0; t < 6; t++) begin
         ctx = t;
         q_out.delete();
         in_cyc.delete();
         drive_frame(tbl[t].pat, tbl[t].ksel, tbl[t].gap, tbl[t].sof_sep);
         check_frame(tbl[t].ex, tbl[t].ey, tbl[t].use_x, 0);
      end

      // sof reasserted at pixel (3,2) of a ramp frame
      ctx = 10;
      q_out.delete();
      in_cyc.delete();
      bus.kernel_sel = 1'b0;
      for (int idx = 0; idx < 2 * W + 3; idx++)
         drive_px(pix(4, idx % W, idx / W), idx == 0);
      drive_px(pix(0, 0, 0), 1'b1);
      sof_cyc = cyc;
      for (int idx = 1; idx < W * H; idx++) begin
         drive_px(pix(0, idx % W, idx / W), 1'b0);
         if (idx % W >= 2 && idx / W >= 2) in_cyc.push_back(cyc);
      end
      repeat (5) idle_cyc(1'b0);
      n_old = 0;
      foreach (q_out[k]) begin
         if (q_out[k].cyc <= sof_cyc + 1) begin
            n_old++;
            chk("old_out{x,y,d}", {11'(q_out[k].x), 10'(q_out[k].y), q_out[k].d},
                {11'd1, 10'd1, 12'd600});
         end
      end
      chk("old_count", n_old, 1);
      check_frame('0, '0, 1'b1, sof_cyc + 2);

      // reset pulsed mid-RUN
      ctx = 11;
      q_out.delete();
      in_cyc.delete();
      for (int idx = 0; idx < 3 * W + 5; idx++)
         drive_px(pix(4, idx % W, idx / W), idx == 0);
      #2;
      chk("pre_rst_out{v,d}", {bus.out_valid, bus.out_data}, {1'b1, 12'd600});
      rst_n = 1'b0;
      #1;
      chk("rst_out", {bus.out_valid, bus.frame_done, bus.out_x, bus.out_y, bus.out_data}, 0);
      bus.gs_valid = 1'b0;
      bus.sof      = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      q_out.delete();
      for (int idx = 0; idx < 2 * W + 6; idx++)
         drive_px(pix(4, idx % W, idx / W), 1'b0);
      repeat (4) idle_cyc(1'b0);
      chk("idle_ignore_count", q_out.size(), 0);
      q_out.delete();
      drive_frame(0, 1'b0, 0, 1'b0);
      check_frame('0, '0, 1'b1, 0);

      chk("frame_done_stray", fd_stray, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/gs_sobel3x3.md
# gs_sobel3x3

Streaming 3x3 Sobel edge-detection stage directly downstream of the Bayer-to-grayscale converter. It consumes the 12-bit grayscale pixel stream in raster order, keeps the two previous rows in internal line buffers, and emits one edge-magnitude pixel per interior input position. The output feeds the SDRAM write-side formatter.

## Interface
- IMG_W, 640, grayscale pixels per row; minimum 4.
- IMG_H, 480, grayscale rows per frame; minimum 3.
- DW, 12, pixel width in bits.

- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- sof  in  1  start-of-frame pulse; qualifies the next accepted pixel as (0,0).
- gs_valid  in  1  input pixel strobe; gaps allowed at any cycle.
- gs_data  in  DW  grayscale pixel.
- kernel_sel  in  1  selects the kernel: 0 = Gx (vertical edges), 1 = Gy (horizontal edges). Sampled at sof only.
- out_valid  out  1  output pixel strobe.
- out_data  out  DW  edge value.
- out_x  out  11  output column (center pixel), range 1..IMG_W-2.
- out_y  out  10  output row (center pixel), range 1..IMG_H-2.
- frame_done  out  1  one-cycle pulse on the cycle the last output pixel is issued.

## Operation
- Input x/y counters advance only on gs_valid. x wraps at IMG_W-1 and then increments y.
- The FSM has three states:
  - IDLE: wait for sof.
  - FILL: rows 0–1.
  - RUN: rows 2..IMG_H-1.
- FSM transitions:
  - IDLE→FILL on sof with gs_valid, or on the first gs_valid after sof.
  - FILL→RUN on acceptance of pixel (IMG_W-1, 1).
  - RUN→IDLE on acceptance of pixel (IMG_W-1, IMG_H-1).
- sof in any state restarts the counters at (0,0), enters FILL, and discards in-flight window contents. Pipeline outputs already issued are not recalled.
- Two line buffers hold rows y-1 and y-2, clock-enabled by gs_valid. A 3x3 window register shifts on gs_valid.
- In RUN, an output is produced when accepting pixel (x,y) with x≥2. The center is (x-1, y-1).
- Border pixels are never emitted, so each frame yields exactly (IMG_W-2)*(IMG_H-2) outputs.
- Gx = [-1 0 1; -2 0 2; -1 0 1]. Gy = its transpose, with the top row negative.
- The sum is signed, DW+3 bits wide, with range ±4*(2^DW-1).
- Output scaling (see Configuration) makes the result always fit DW bits, with no saturation logic.
- Input pixels accepted in IDLE without sof are ignored.

## Timing
- Two-stage pipeline:
  - Stage 1 registers the kernel sum.
  - Stage 2 registers abs/clamp, scaling, and coordinates.
- out_valid is asserted exactly 2 cycles after the gs_valid cycle that completes the window. Gaps in gs_valid propagate one-for-one.
- There is no backpressure; the consumer accepts every out_valid.
- frame_done coincides with out_valid for center (IMG_W-2, IMG_H-2).
- Reset values: out_valid=0, out_data=0, out_x=0, out_y=0, frame_done=0, state=IDLE, counters=0.
- Line buffer contents are not reset.
- Asserting reset mid-frame drops all pending outputs. The block then waits for sof.

## Configuration
- CONV_ABS_EN defined: out_data = |sum| >> 2. Rising and falling edges both produce magnitude.
- CONV_ABS_EN undefined: out_data = (sum<0) ? 0 : sum >> 2. Only positive-going edges are produced, and the abs logic is removed.

## Structure
- Shared package gs_pkg holds:
  - the state_t enum {IDLE, FILL, RUN};
  - the DW default;
  - the kernel_t enum {KERN_GX, KERN_GY};
  - the SUM_W = DW+3 constant.
- One sub-module, gs_line_buffer: a parameterized-depth (IMG_W), DW-wide clock-enabled shift register with a single tap at the end. It is instantiated twice, in cascade.

## Test plan
- Flat frame, IMG_W=8, IMG_H=6, all pixels 100, gs_valid continuous → exactly 24 outputs, all out_data=0, and frame_done on (6,4).
- Vertical step (columns 0–4 = 0, 5–7 = 4095) with kernel_sel=0 → out_data=4095 at x=4,5 on every row and 0 elsewhere.
  - Inverted step without CONV_ABS_EN → all 0.
  - Inverted step with CONV_ABS_EN → 4095 at x=4,5.
- Horizontal step (rows 0–2 = 0, rows 3–5 = 2000) with kernel_sel=1 → 2000 at y=2,3 and 0 at y=1,4.
- gs_valid asserted every other cycle, with the flat-frame stimulus → 24 outputs, each exactly 2 cycles after its completing input.
- sof reasserted at pixel (3,2) of a frame → no output carries a coordinate from the aborted frame after the pipeline drains. The new frame yields exactly 24 outputs.
- rst_n pulsed low mid-RUN → all outputs go to 0 immediately. No out_valid until sof, followed by a full frame of 24 outputs.
